// File: rtl/rtc_mc_if_p_if.sv
// rtc_mc_if_p_if: wrapper-side and register-file-side buses of the CAN microcontroller interface
interface rtc_mc_if_p_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 31
);
  logic [DATA_W-1:0]   i_bus_data;
  logic [ADDR_W-1:0]   i_addr;
  logic                i_r_neg_w;
  logic                i_cs;
  logic [DATA_W-1:0]   o_reg_data;
  logic                o_ack;
  logic                o_error;
  logic                o_busy;
  logic [DATA_W-1:0]   i_reg_r_data;
  logic                i_reg_ack;
  logic                i_reg_error;
  logic [DATA_W-1:0]   o_reg_w_bus;
  logic [NUM_REGS-1:0] o_rs_vector;
  logic                o_r_neg_w;
  modport slave (
    input  i_bus_data, i_addr, i_r_neg_w, i_cs, i_reg_r_data, i_reg_ack, i_reg_error,
    output o_reg_data, o_ack, o_error, o_busy, o_reg_w_bus, o_rs_vector, o_r_neg_w
  );
  modport master (
    output i_bus_data, i_addr, i_r_neg_w, i_cs, i_reg_r_data, i_reg_ack, i_reg_error,
    input  o_reg_data, o_ack, o_error, o_busy, o_reg_w_bus, o_rs_vector, o_r_neg_w
  );
endinterface

// File: rtl/rtc_mc_if_p.sv
// rtc_mc_if_p: wrapper-bus to config-register bridge with one-hot select and ack FSM; MC_IF_TIMEOUT_EN adds an ack timeout
module rtc_mc_if_p #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 6,
  parameter int NUM_REGS       = 31,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          i_sys_clk,
  input logic          i_reset_n,
  rtc_mc_if_p_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECODE, WAIT_ACK, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              r_neg_w_q;
  logic [DATA_W-1:0] data_q;
  logic              mapped;
  logic              changed;
  logic              timeout;
  assign mapped  = int'(addr_q) < NUM_REGS;
  assign changed = bus.i_addr != addr_q || bus.i_r_neg_w != r_neg_w_q;
`ifdef MC_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_sys_clk or negedge i_reset_n)
    if (!i_reset_n) cnt <= '0;
    else cnt <= state == WAIT_ACK ? cnt + 1'b1 : '0;
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge i_sys_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      r_neg_w_q       <= 1'b0;
      data_q          <= '0;
      bus.o_reg_data  <= '0;
      bus.o_ack       <= 1'b0;
      bus.o_error     <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_reg_w_bus <= '0;
      bus.o_rs_vector <= '0;
      bus.o_r_neg_w   <= 1'b0;
    end else begin
      bus.o_ack   <= 1'b0;
      bus.o_error <= 1'b0;
      case (state)
        IDLE, DONE:
          if (bus.i_cs && (state == IDLE || changed)) begin
            addr_q     <= bus.i_addr;
            r_neg_w_q  <= bus.i_r_neg_w;
            data_q     <= bus.i_bus_data;
            bus.o_busy <= 1'b1;
            state      <= DECODE;
          end else if (!bus.i_cs) state <= IDLE;
        DECODE:
          if (!bus.i_cs) begin
            bus.o_busy <= 1'b0;
            state      <= IDLE;
          end else if (mapped) begin
            bus.o_rs_vector <= NUM_REGS'(1) << addr_q;
            bus.o_r_neg_w   <= r_neg_w_q;
            if (!r_neg_w_q) bus.o_reg_w_bus <= data_q;
            state <= WAIT_ACK;
          end else begin
            bus.o_ack   <= 1'b1;
            bus.o_error <= 1'b1;
            if (r_neg_w_q) bus.o_reg_data <= '0;
            bus.o_busy  <= 1'b0;
            state       <= DONE;
          end
        default:
          if (!bus.i_cs) begin
            bus.o_rs_vector <= '0;
            bus.o_busy      <= 1'b0;
            state           <= IDLE;
          end else if (bus.i_reg_ack || timeout) begin
            // a real ack beats a timeout landing on the same cycle
            bus.o_ack       <= 1'b1;
            bus.o_error     <= !bus.i_reg_ack || bus.i_reg_error;
            if (r_neg_w_q) bus.o_reg_data <= bus.i_reg_ack ? bus.i_reg_r_data : '0;
            bus.o_rs_vector <= '0;
            bus.o_busy      <= 1'b0;
            state           <= DONE;
          end
      endcase
    end
endmodule

// File: tb/tb_rtc_mc_if_p.sv
// tb_rtc_mc_if_p: randomized transaction-level check of rtc_mc_if_p against a scoreboard model
module tb_rtc_mc_if_p;
`ifdef MC_IF_TIMEOUT_EN
  localparam int TO = 16;
`endif
  logic i_sys_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_wb = '0;
  logic [5:0] prev_addr = '0;
  logic prev_rnw = 1'b0;
  bit in_done = 0;
  rtc_mc_if_p_if #(.DATA_W(32), .ADDR_W(6), .NUM_REGS(31)) bus ();
  rtc_mc_if_p #(.DATA_W(32), .ADDR_W(6), .NUM_REGS(31), .TIMEOUT_CYCLES(16)) dut (
    .i_sys_clk(i_sys_clk),
    .i_reset_n(i_reset_n),
    .bus(bus)
  );
  always #5 i_sys_clk = ~i_sys_clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask
  task automatic check_outs(input string tag, input logic ack, input logic err, input logic busy, input logic [30:0] rs);
    check({tag, "_ack"}, 64'(bus.o_ack), 64'(ack));
    check({tag, "_err"}, 64'(bus.o_error), 64'(err));
    check({tag, "_busy"}, 64'(bus.o_busy), 64'(busy));
    check({tag, "_rs"}, 64'(bus.o_rs_vector), 64'(rs));
  endtask
  task automatic check_data(input string tag);
    check({tag, "_rd"}, 64'(bus.o_reg_data), 64'(exp_rd));
    check({tag, "_wb"}, 64'(bus.o_reg_w_bus), 64'(exp_wb));
  endtask
  task automatic finish_access(input logic [5:0] a, input logic rnw);
    prev_addr = a;
    prev_rnw = rnw;
    in_done = 1;
  endtask
  // kind: 0 normal, 1 drop cs during decode, 2 drop cs in wait together with a register ack
  task automatic access(input logic [5:0] a, input logic rnw, input logic [31:0] d, input int dly, input logic err, input int kind);
    logic [31:0] rdat;
    logic [30:0] oh;
    bit mapped;
    mapped = a < 6'd31;
    bus.i_cs = 1'b1;
    bus.i_addr = a;
    bus.i_r_neg_w = rnw;
    bus.i_bus_data = d;
    if (in_done && a == prev_addr && rnw == prev_rnw) begin
      repeat (3) begin
        bus.i_reg_ack = 1'($urandom);
        tick();
        check_outs("hold", 1'b0, 1'b0, 1'b0, '0);
      end
      bus.i_reg_ack = 1'b0;
      check_data("hold");
      return;
    end
    tick();
    check_outs("decode", 1'b0, 1'b0, 1'b1, '0);
    if (kind == 1) begin
      bus.i_cs = 1'b0;
      tick();
      check_outs("abort_dec", 1'b0, 1'b0, 1'b0, '0);
      check_data("abort_dec");
      in_done = 0;
      return;
    end
    tick();
    if (!mapped) begin
      if (rnw) exp_rd = '0;
      check_outs("unmapped", 1'b1, 1'b1, 1'b0, '0);
      check_data("unmapped");
      finish_access(a, rnw);
      return;
    end
    oh = '0;
    oh[a[4:0]] = 1'b1;
    if (!rnw) exp_wb = d;
    check_outs("select", 1'b0, 1'b0, 1'b1, oh);
    check("select_dir", 64'(bus.o_r_neg_w), 64'(rnw));
    check_data("select");
    if (kind == 2) begin
      bus.i_reg_ack = 1'b1;
      bus.i_cs = 1'b0;
      tick();
      bus.i_reg_ack = 1'b0;
      check_outs("abort_wait", 1'b0, 1'b0, 1'b0, '0);
      check_data("abort_wait");
      in_done = 0;
      return;
    end
    for (int i = 0; i < dly; i++) begin
      tick();
`ifdef MC_IF_TIMEOUT_EN
      if (i == TO - 1) begin
        if (rnw) exp_rd = '0;
        check_outs("timeout", 1'b1, 1'b1, 1'b0, '0);
        check_data("timeout");
        finish_access(a, rnw);
        return;
      end
`endif
      check_outs("wait", 1'b0, 1'b0, 1'b1, oh);
    end
    rdat = $urandom;
    bus.i_reg_r_data = rdat;
    bus.i_reg_error = err;
    bus.i_reg_ack = 1'b1;
    tick();
    bus.i_reg_ack = 1'b0;
    bus.i_reg_error = 1'b0;
    if (rnw) exp_rd = rdat;
    check_outs("ack", 1'b1, err, 1'b0, '0);
    check_data("ack");
    finish_access(a, rnw);
  endtask
  task automatic drop_cs(input int n);
    bus.i_cs = 1'b0;
    repeat (n) begin
      bus.i_reg_ack = 1'($urandom);
      tick();
      check_outs("idle", 1'b0, 1'b0, 1'b0, '0);
    end
    bus.i_reg_ack = 1'b0;
    in_done = 0;
  endtask
  initial begin
    logic [5:0] a;
    logic rnw;
    int kind;
    bus.i_cs = 1'b0;
    bus.i_addr = '0;
    bus.i_r_neg_w = 1'b0;
    bus.i_bus_data = '0;
    bus.i_reg_r_data = '0;
    bus.i_reg_ack = 1'b0;
    bus.i_reg_error = 1'b0;
    repeat (2) tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, '0);
    check_data("reset");
    check("reset_dir", 64'(bus.o_r_neg_w), 64'(0));
    i_reset_n = 1'b1;
    tick();
    access(6'h00, 1'b1, 32'h0, 2, 1'b0, 0);
    drop_cs(2);
    access(6'h30, 1'b1, 32'h0, 0, 1'b0, 0);
    drop_cs(1);
    access(6'h1E, 1'b0, 32'h03, 1, 1'b0, 0);
    drop_cs(1);
    access(6'h30, 1'b0, 32'h04, 0, 1'b0, 0);
    drop_cs(1);
    access(6'h1F, 1'b1, 32'h0, 0, 1'b0, 0);
    drop_cs(1);
    access(6'h00, 1'b1, 32'h0, 0, 1'b1, 0);
    access(6'h05, 1'b0, 32'h03, 3, 1'b0, 0);
    access(6'h05, 1'b0, 32'h77, 0, 1'b0, 0);
    access(6'h05, 1'b1, 32'h0, 0, 1'b0, 0);
    drop_cs(1);
    access(6'h07, 1'b0, 32'h55, 0, 1'b0, 2);
    access(6'h08, 1'b0, 32'h66, 0, 1'b0, 1);
    access(6'h02, 1'b1, 32'h0, 100, 1'b0, 0);
    drop_cs(1);
    access(6'h0A, 1'b0, 32'hABCD, 0, 1'b0, 0);
    drop_cs(1);
    bus.i_cs = 1'b1;
    bus.i_addr = 6'h04;
    bus.i_r_neg_w = 1'b1;
    repeat (2) tick();
    i_reset_n = 1'b0;
    #1;
    exp_rd = '0;
    exp_wb = '0;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, '0);
    check_data("async_rst");
    check("async_rst_dir", 64'(bus.o_r_neg_w), 64'(0));
    tick();
    bus.i_cs = 1'b0;
    i_reset_n = 1'b1;
    in_done = 0;
    tick();
    check_outs("post_rst", 1'b0, 1'b0, 1'b0, '0);
    repeat (200) begin
      a = $urandom_range(0, 9) < 7 ? 6'($urandom_range(0, 30)) : 6'($urandom_range(31, 63));
      rnw = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        a = prev_addr;
        rnw = prev_rnw;
      end
      kind = $urandom_range(0, 9);
      kind = kind == 0 ? 1 : kind == 1 ? 2 : 0;
      access(a, rnw, $urandom, $urandom_range(0, 20), 1'($urandom), kind);
      if ($urandom_range(0, 2) == 0) drop_cs($urandom_range(1, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
